// File: rtl/ahb_lite_cmd_master.sv
// ---------------------------------------------------------------------------
// ahb_lite_cmd_master
//
// AHB-Lite initiator. Turns single-word read/write commands from a local
// valid/ready port into AHB-Lite NONSEQ word transfers and returns exactly one
// response per command. Only one transfer is in flight at a time. A data phase
// that keeps HREADY low for TIMEOUT cycles is aborted and reported as an error.
//
// Parameters
//   TIMEOUT    max HREADY-low data-phase cycles before abort; 0 = never abort
//
// Ports
//   HCLK       in   bus clock, all logic on the rising edge
//   HRESET     in   synchronous, active-high reset
//   cmd_valid  in   command present
//   cmd_ready  out  command accepted on this edge when cmd_valid is high
//   cmd_write  in   1 = write, 0 = read
//   cmd_addr   in   byte address, bits [1:0] ignored
//   cmd_wdata  in   write data
//   rsp_valid  out  one-cycle response pulse
//   rsp_rdata  out  read data, 0 for writes and errors
//   rsp_err    out  bus ERROR or timeout
//   rsp_tout   out  the error was a timeout
//   HADDR      out  bus address (word aligned)
//   HTRANS     out  IDLE (00) or NONSEQ (10)
//   HWRITE     out  bus direction
//   HSIZE      out  always word (010)
//   HWDATA     out  write data, held for the whole data phase
//   HRDATA     in   read data from the slave mux
//   HREADY     in   transfer complete / bus ready
//   HRESP      in   1 = ERROR
// ---------------------------------------------------------------------------
module ahb_lite_cmd_master #(
  parameter logic [15:0] TIMEOUT = 16'd1024
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_tout,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;

  logic [1:0]  state;
  logic [31:0] wdata_q;
  logic [15:0] wait_cnt;
  logic [15:0] wait_nxt;
  logic        timeout_hit;

  // The response cycle is already IDLE, so a new command can be taken while
  // rsp_valid is high; this gives one command every three cycles.
  assign cmd_ready = (state == ST_IDLE);
  assign HSIZE     = 3'b010;

  // Count the current HREADY-low edge before comparing, so the abort fires on
  // the edge where the TIMEOUT-th wait state is seen.
  assign wait_nxt    = wait_cnt + 16'd1;
  assign timeout_hit = (TIMEOUT != 16'd0) && (wait_nxt == TIMEOUT);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge HCLK) begin
    // NOTE: every register, including the command holding register, is reset
    // so a transfer in flight is dropped cleanly with no stale response.
    if (HRESET) begin
      state     <= ST_IDLE;
      wdata_q   <= '0;
      wait_cnt  <= '0;
      HADDR     <= '0;
      HTRANS    <= TRANS_IDLE;
      HWRITE    <= 1'b0;
      HWDATA    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      rsp_tout  <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            // Masking keeps all address bits in use while forcing alignment.
            HADDR    <= cmd_addr & 32'hFFFF_FFFC;
            HWRITE   <= cmd_write;
            wdata_q  <= cmd_wdata;
            HTRANS   <= TRANS_NONSEQ;
            wait_cnt <= '0;
            state    <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          // Address-phase signals simply hold while the bus stalls.
          if (HREADY) begin
            HTRANS <= TRANS_IDLE;
            HWDATA <= wdata_q;
            state  <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (HREADY) begin
            rsp_valid <= 1'b1;
            rsp_err   <= HRESP;
            rsp_tout  <= 1'b0;
            rsp_rdata <= (!HWRITE && !HRESP) ? HRDATA : 32'd0;
            state     <= ST_IDLE;
          end else begin
            // The first cycle of a two-cycle ERROR lands here as a plain wait.
            if (wait_cnt != 16'hFFFF) wait_cnt <= wait_nxt;
            if (timeout_hit) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_tout  <= 1'b1;
              rsp_rdata <= '0;
              state     <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
